// File: rtl/freq_div_pkg.sv
// Shared types and constants for the freq_div_ctrl divided-clock controller.
package freq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_core.sv
// Divide-by-N period counter with registered tick / divided-clock decode.
// Outputs are computed from the next counter value so they leave flops directly.
module freq_div_core #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] ld_div,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             div_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE1 = (CNT_W+1)'(1);

    logic             act;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W:0]   half;

    assign wrap = act && (cnt == div_q - ONE);

    // A new period starts on entry to running, on a ratio load, or at wrap.
    always_comb begin
        div_nxt = load ? ld_div : div_q;
        cnt_nxt = '0;
        if (run && act && !load && !wrap)
            cnt_nxt = cnt + ONE;
        half = ({1'b0, div_nxt} + ONE1) >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act     <= 1'b0;
            cnt     <= '0;
            div_q   <= CNT_W'(DEF_DIV);
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            act     <= run;
            cnt     <= cnt_nxt;
            div_q   <= div_nxt;
            tick    <= run && (cnt_nxt == '0);
            div_out <= run && ({1'b0, cnt_nxt} < half);
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Run/stop sequencing and ratio-change handshake around freq_div_core.
// Define FREQ_DIV_CTRL_RANGE_CHK_EN to reject ratios below 2 instead of clamping.
import freq_div_pkg::*;

module freq_div_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic             div_out,
    output logic             tick
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] req_div;
    logic [CNT_W-1:0] ld_div;
    logic [CNT_W-1:0] cnt;
    logic             req_ok;
    logic             req_bad;
    logic             err_set;
    logic             run;
    logic             load;
    logic             wrap;

`ifdef FREQ_DIV_CTRL_RANGE_CHK_EN
    assign req_bad = (div_val < CNT_W'(MIN_DIV));
    assign req_div = div_val;
`else
    assign req_bad = 1'b0;
    assign req_div = (div_val < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : div_val;
`endif

    // A request still high while its ack/err is visible belongs to the old transaction.
    assign req_ok = div_req && !div_ack && !div_err;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        err_set   = 1'b0;
        ld_div    = req_div;
        case (state)
            IDLE: begin
                load    = req_ok && !req_bad;
                err_set = req_ok && req_bad;
                if (en)
                    state_nxt = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    err_set = req_ok && req_bad;
                    if (req_ok && !req_bad)
                        state_nxt = PEND;
                end
            end
            PEND: begin
                ld_div = pend_div;
                if (!en) begin
                    state_nxt = IDLE;
                    load      = 1'b1;
                end else if (wrap) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        run = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_div  <= CNT_W'(DEF_DIV);
            pend_div <= '0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_ack <= load;
            div_err <= err_set;
            busy    <= (state_nxt == PEND);
            if (load)
                cur_div <= ld_div;
            if (state == RUN && state_nxt == PEND)
                pend_div <= req_div;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE)
            assert (cnt == '0);
    end

    freq_div_core #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .load    (load),
        .ld_div  (ld_div),
        .cnt     (cnt),
        .wrap    (wrap),
        .div_out (div_out),
        .tick    (tick)
    );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: a period/phase reference model predicts every cycle's outputs.
module tb_freq_div_ctrl;

    localparam int CNT_W   = 8;
    localparam int DEF_DIV = 4;
`ifdef FREQ_DIV_CTRL_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             rst     = 1'b1;
    logic             en      = 1'b0;
    logic             div_req = 1'b0;
    logic [CNT_W-1:0] div_val = '0;
    logic             div_ack;
    logic             div_err;
    logic             busy;
    logic [CNT_W-1:0] cur_div;
    logic             div_out;
    logic             tick;

    always #5 clk = ~clk;

    freq_div_ctrl #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .div_ack (div_ack),
        .div_err (div_err),
        .busy    (busy),
        .cur_div (cur_div),
        .div_out (div_out),
        .tick    (tick)
    );

    typedef struct packed {
        logic             tick;
        logic             div_out;
        logic             ack;
        logic             err;
        logic             busy;
        logic [CNT_W-1:0] cur;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          req_at_edge = 1'b0;

    // Reference model: is the divider running, which phase of the period, which ratios.
    bit m_run, m_pend, m_ack, m_err;
    int m_phase, m_cur, m_pdiv;

    task automatic model_edge();
        bit valid, bad, nack, nerr;
        int v;
        nack = 1'b0;
        nerr = 1'b0;
        if (rst) begin
            m_run = 0; m_pend = 0; m_phase = 0; m_cur = DEF_DIV;
        end else begin
            valid = div_req && !m_ack && !m_err;
            v     = int'(div_val);
            bad   = RANGE_CHK && (v < 2);
            if (!RANGE_CHK && v < 2) v = 2;
            if (!m_run) begin
                if (valid && bad) nerr = 1;
                else if (valid) begin m_cur = v; nack = 1; end
                m_phase = 0;
                m_run   = en;
            end else if (m_pend) begin
                if (!en) begin
                    m_cur = m_pdiv; nack = 1; m_pend = 0; m_run = 0; m_phase = 0;
                end else if (m_phase == m_cur - 1) begin
                    m_cur = m_pdiv; nack = 1; m_pend = 0; m_phase = 0;
                end else begin
                    m_phase++;
                end
            end else begin
                if (!en) begin
                    m_run = 0; m_phase = 0;
                end else begin
                    if (valid && bad) nerr = 1;
                    else if (valid) begin m_pdiv = v; m_pend = 1; end
                    m_phase = (m_phase == m_cur - 1) ? 0 : m_phase + 1;
                end
            end
        end
        m_ack = nack;
        m_err = nerr;
    endtask

    task automatic cyc();
        obs_t e;
        @(posedge clk);
        model_edge();
        e.tick    = m_run && (m_phase == 0);
        e.div_out = m_run && (m_phase < (m_cur + 1) / 2);
        e.ack     = m_ack;
        e.err     = m_err;
        e.busy    = m_pend;
        e.cur     = CNT_W'(m_cur);
        exp_q.push_back(e);
        req_at_edge = div_req;
        #1;
        if (div_req && (m_ack || m_err))
            div_req = 1'b0;
    endtask

    task automatic request(input int v);
        int guard;
        guard = 0;
        while ((div_req || req_at_edge) && guard < 600) begin
            cyc();
            guard++;
        end
        if (guard >= 600) begin
            n_cmp++; n_bad++;
            $display("FAIL request_wait: requester still busy after %0d cycles, required idle", guard);
        end
        div_val = CNT_W'(v);
        div_req = 1'b1;
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        while (!(m_run && m_phase == ph) && guard < 600) begin
            cyc();
            guard++;
        end
        if (guard >= 600) begin
            n_cmp++; n_bad++;
            $display("FAIL phase_wait: phase %0d not reached, required %0d", m_phase, ph);
        end
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {tick, div_out, div_ack, div_err, busy, cur_div};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL outputs @%0t: got tick=%b div_out=%b ack=%b err=%b busy=%b cur=%0d, required tick=%b div_out=%b ack=%b err=%b busy=%b cur=%0d",
                             $time, a.tick, a.div_out, a.ack, a.err, a.busy, a.cur,
                             e.tick, e.div_out, e.ack, e.err, e.busy, e.cur);
                end
            end
        end
    end

    initial begin : stimulus
        int r;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        en = 1'b1;
        repeat (9) cyc();
        // change to 3 requested mid-period
        wait_phase(1);
        div_val = 8'd3;
        div_req = 1'b1;
        repeat (12) cyc();
        en = 1'b0;
        repeat (2) cyc();
        request(7);
        repeat (3) cyc();
        en = 1'b1;
        repeat (16) cyc();
        request(5);
        repeat (15) cyc();
        wait_phase(2);
        en = 1'b0;
        repeat (2) cyc();
        en = 1'b1;
        repeat (6) cyc();
        request(1);
        repeat (10) cyc();
        request(6);
        cyc();
        cyc();
        rst     = 1'b1;
        div_req = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        request(2);
        repeat (10) cyc();
        en = 1'b0;
        request(2);
        en = 1'b1;
        repeat (6) cyc();

        repeat (3000) begin
            if (rst) rst = 1'b0;
            r = int'($urandom_range(0, 199));
            if (r < 4)
                en = !en;
            else if (r < 30 && !div_req && !req_at_edge) begin
                div_val = (r == 29) ? CNT_W'($urandom_range(0, 255)) : CNT_W'($urandom_range(0, 9));
                div_req = 1'b1;
            end else if (r == 199) begin
                rst     = 1'b1;
                div_req = 1'b0;
            end
            cyc();
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
